// File: rtl/fifo_frame_pkg.sv
// Shared types for the FIFO frame reader: parser states and header field positions.
package fifo_frame_pkg;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PAY  = 2'd1,
      S_DROP = 2'd2
   } state_e;

   localparam int HDR_LEN_LSB = 0;

   function automatic int hdr_len_msb(input int len_w);
      return HDR_LEN_LSB + len_w - 1;
   endfunction

   // MSB for the default 8-bit length field; the top derives its own from LEN_W.
   localparam int HDR_LEN_MSB = hdr_len_msb(8);

endpackage

// File: rtl/fifo_frame_reader_ostage.sv
// Output register for the frame reader: holds data/last under backpressure, clears on accept or abort.
module fifo_frame_reader_ostage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             last_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (clear_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
         last_d  = last_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Parses length-prefixed frames from a FIFO and streams the payload out over valid/ready.
// Frame counter is built only when FIFO_FRAME_READER_STATS_EN is defined; otherwise frame_count is 0.
//
// state  | meaning
// S_HDR  | waiting for / popping a header word
// S_PAY  | popping payload words into the output stage
// S_DROP | discarding the rest of a flushed frame
module fifo_frame_reader
   import fifo_frame_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int LEN_W   = 8,
   parameter int STATS_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   fifo_data,
   input  logic               fifo_empty,
   output logic               fifo_re,
   input  logic               flush,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   output logic               busy,
   output logic [STATS_W-1:0] frame_count
);

   localparam int LEN_MSB = hdr_len_msb(LEN_W);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] hdr_len;
   logic             pay_load;
   logic             pay_last;
   logic             ost_clear;
   logic             frame_done;

   assign hdr_len = fifo_data[LEN_MSB:HDR_LEN_LSB];

   // fifo_re is gated by rst so nothing is popped while the block is held in reset.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fifo_re    = 1'b0;
      pay_load   = 1'b0;
      pay_last   = 1'b0;
      ost_clear  = 1'b0;
      frame_done = 1'b0;
      if (rst) begin
         case (state_q)
            S_HDR: begin
               if (!fifo_empty) begin
                  fifo_re = 1'b1;
                  cnt_d   = hdr_len;
                  if (hdr_len != '0) state_d = S_PAY;
               end
            end
            S_PAY: begin
               if (flush) begin
                  ost_clear = 1'b1;
                  state_d   = (cnt_q != '0) ? S_DROP : S_HDR;
               end else if (!fifo_empty && (!m_valid || m_ready)) begin
                  fifo_re  = 1'b1;
                  pay_load = 1'b1;
                  pay_last = (cnt_q == LEN_W'(1));
                  cnt_d    = cnt_q - LEN_W'(1);
                  if (pay_last) begin
                     state_d    = S_HDR;
                     frame_done = 1'b1;
                  end
               end
            end
            S_DROP: begin
               if (!fifo_empty) begin
                  fifo_re = 1'b1;
                  cnt_d   = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) state_d = S_HDR;
               end
            end
            default: state_d = S_HDR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_HDR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   fifo_frame_reader_ostage #(
      .WIDTH(WIDTH)
   ) u_ostage (
      .clk     (clk),
      .rst     (rst),
      .load_i  (pay_load),
      .clear_i (ost_clear),
      .data_i  (fifo_data),
      .last_i  (pay_last),
      .ready_i (m_ready),
      .data_o  (m_data),
      .valid_o (m_valid),
      .last_o  (m_last)
   );

   assign busy = (state_q != S_HDR);

`ifdef FIFO_FRAME_READER_STATS_EN
   logic [STATS_W-1:0] frames_q, frames_d;

   assign frames_d = frame_done ? frames_q + STATS_W'(1) : frames_q;

   always_ff @(posedge clk) begin
      if (!rst) frames_q <= '0;
      else      frames_q <= frames_d;
   end

   assign frame_count = frames_q;
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done;
   assign frame_count       = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: directed frames through a queue-modelled FIFO.
module tb_fifo_frame_reader;

   localparam int WIDTH   = 16;
   localparam int LEN_W   = 8;
   localparam int STATS_W = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [WIDTH-1:0]   fifo_data;
   logic               fifo_empty;
   logic               fifo_re;
   logic               flush = 1'b0;
   logic [WIDTH-1:0]   m_data;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic               m_last;
   logic               busy;
   logic [STATS_W-1:0] frame_count;

   fifo_frame_reader #(
      .WIDTH(WIDTH), .LEN_W(LEN_W), .STATS_W(STATS_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_data   (fifo_data),
      .fifo_empty  (fifo_empty),
      .fifo_re     (fifo_re),
      .flush       (flush),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             l;
   } exp_t;

   int               tests = 0;
   int               fails = 0;
   int               pops  = 0;
   int               viol  = 0;
   logic [WIDTH-1:0] fifo_q[$];
   exp_t             sb[$];
   logic             empty_mask = 1'b0;
   logic             toggle_en  = 1'b0;
   logic             pop_now    = 1'b0;

   task automatic fifo_refresh();
      fifo_empty = (fifo_q.size() == 0) || empty_mask;
      fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      fifo_q.push_back(w);
      fifo_refresh();
   endtask

   task automatic expect_word(input logic [WIDTH-1:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [STATS_W-1:0] fc_exp(input int n);
`ifdef FIFO_FRAME_READER_STATS_EN
      return STATS_W'(n);
`else
      return (n < 0) ? STATS_W'(1) : '0;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((sb.size() != 0 || fifo_q.size() != 0 || busy || m_valid) && n < budget) begin
         tick(1);
         n++;
      end
      tick(2);
      tests++;
      if (n >= budget) begin
         fails++;
         $display("FAIL %s: drain timed out after %0d cycles, %0d words still expected", name, n, sb.size());
      end
   endtask

   // FIFO model: pop decision taken mid-cycle, applied just after the edge the DUT sampled.
   always @(negedge clk) begin
      pop_now = fifo_re && !fifo_empty;
      if (fifo_re && fifo_empty) viol++;
   end

   always @(posedge clk) begin
      #1;
      if (pop_now && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      empty_mask = toggle_en ? ~empty_mask : 1'b0;
      fifo_refresh();
   end

   // Monitor: every handshake must match the next expected word.
   always @(negedge clk) begin
      exp_t e;
      if (rst && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got data %0h last %0b, expected no output", m_data, m_last);
         end else begin
            e = sb.pop_front();
            check("sb_data", m_data, e.d);
            check("sb_last", m_last, e.l);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      fifo_refresh();
      rst = 1'b0;
      tick(2);
      check("rst_valid", m_valid, 0);
      check("rst_last",  m_last,  0);
      check("rst_data",  m_data,  0);
      check("rst_busy",  busy,    0);
      check("rst_fc",    frame_count, fc_exp(0));
      rst = 1'b1;
      tick(1);

      // Frame of 3 at full rate
      m_ready = 1'b1;
      pops = 0;
      push(16'd3); push(16'hA00A); push(16'hB00B); push(16'hC00C);
      expect_word(16'hA00A, 1'b0); expect_word(16'hB00B, 1'b0); expect_word(16'hC00C, 1'b1);
      tick(4);
      check("s1_pops_4cyc", pops, 4);
      check("s1_fifo_left", fifo_q.size(), 0);
      wait_drain("s1_drain", 50);
      check("s1_fc", frame_count, fc_exp(1));

      // Empty frame then single-word frame
      pops = 0;
      push(16'd0); push(16'd1); push(16'hD00D);
      expect_word(16'hD00D, 1'b1);
      wait_drain("s2_drain", 50);
      check("s2_pops", pops, 3);
      check("s2_fc", frame_count, fc_exp(2));

      // Backpressure: E held while m_ready low for 5 cycles
      m_ready = 1'b0;
      push(16'd2); push(16'hE00E); push(16'hF00F);
      expect_word(16'hE00E, 1'b0); expect_word(16'hF00F, 1'b1);
      tick(2);
      check("s3_valid_e", m_valid, 1);
      check("s3_data_e",  m_data,  16'hE00E);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("s3_no_pop_stall", fifo_re, 0);
         check("s3_hold_valid",   m_valid, 1);
         check("s3_hold_data",    m_data,  16'hE00E);
         check("s3_hold_last",    m_last,  0);
         check("s3_fifo_left",    fifo_q.size(), 1);
      end
      m_ready = 1'b1;
      wait_drain("s3_drain", 50);
      check("s3_fc", frame_count, fc_exp(3));

      // Flush after H is accepted; I and J are discarded, next frame K parses normally
      pops = 0;
      push(16'd4); push(16'h0006); push(16'h0008);
      expect_word(16'h0006, 1'b0); expect_word(16'h0008, 1'b0);
      tick(4);
      check("s4_pre_flush_busy",  busy,    1);
      check("s4_pre_flush_valid", m_valid, 0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("s4_drop_busy",  busy,    1);
      check("s4_drop_valid", m_valid, 0);
      check("s4_drop_last",  m_last,  0);
      check("s4_fc_nochange", frame_count, fc_exp(3));
      push(16'h0009); push(16'h000A); push(16'd1); push(16'h000B);
      expect_word(16'h000B, 1'b1);
      wait_drain("s4_drain", 50);
      check("s4_pops", pops, 7);
      check("s4_fc", frame_count, fc_exp(4));

      // 5-word frame with fifo_empty toggling every cycle
      toggle_en = 1'b1;
      push(16'd5);
      for (int i = 0; i < 5; i++) begin
         push(16'h5100 + 16'(i));
         expect_word(16'h5100 + 16'(i), (i == 4));
      end
      wait_drain("s5_drain", 100);
      toggle_en = 1'b0;
      check("s5_no_pop_while_empty", viol, 0);
      check("s5_fc", frame_count, fc_exp(5));

      // Maximum length with non-length header bits set
      pops = 0;
      push(16'hC3FF);
      for (int i = 0; i < 255; i++) begin
         push(16'h1000 + 16'(i));
         expect_word(16'h1000 + 16'(i), (i == 254));
      end
      wait_drain("s6_drain", 600);
      check("s6_pops", pops, 256);
      check("s6_fc", frame_count, fc_exp(6));

      // Reset mid-payload
      m_ready = 1'b0;
      push(16'd4); push(16'h7000); push(16'h7001); push(16'h7002); push(16'h7003);
      tick(2);
      check("s7_valid_pre", m_valid, 1);
      check("s7_data_pre",  m_data,  16'h7000);
      check("s7_busy_pre",  busy,    1);
      rst = 1'b0;
      check("s7_re_in_rst0", fifo_re, 0);
      tick(1);
      check("s7_re_in_rst1", fifo_re, 0);
      check("s7_valid", m_valid, 0);
      check("s7_last",  m_last,  0);
      check("s7_data",  m_data,  0);
      check("s7_busy",  busy,    0);
      check("s7_fc",    frame_count, fc_exp(0));
      tick(1);
      check("s7_re_in_rst2", fifo_re, 0);
      check("s7_fifo_kept",  fifo_q.size(), 3);
      fifo_q.delete();
      sb.delete();
      fifo_refresh();
      rst = 1'b1;
      m_ready = 1'b1;
      tick(1);
      push(16'd1); push(16'h7777);
      expect_word(16'h7777, 1'b1);
      wait_drain("s7_drain", 50);
      check("s7_fc_after", frame_count, fc_exp(1));
      check("final_no_pop_while_empty", viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning FIFO word and output data width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning header length-field width, taken from header bits [LEN_W-1:0]; LEN_W <= WIDTH.
REQ-003 SHALL have parameter STATS_W, default 16, meaning frame counter width.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port fifo_data  in  WIDTH  FIFO head word, combinational from the FIFO read pointer.
REQ-007 SHALL have port fifo_empty  in  1  FIFO empty flag.
REQ-008 SHALL have port fifo_re  out  1  FIFO pop strobe, combinational, one word per asserted cycle.
REQ-009 SHALL have port flush  in  1  abort the current frame and discard its remaining payload.
REQ-010 SHALL have port m_data  out  WIDTH  output payload word.
REQ-011 SHALL have port m_valid  out  1  m_data valid.
REQ-012 SHALL have port m_ready  in  1  downstream accept; transfer when m_valid && m_ready.
REQ-013 SHALL have port m_last  out  1  qualifies the final payload word of a frame.
REQ-014 SHALL have port busy  out  1  high in S_PAY or S_DROP.
REQ-015 SHALL have port frame_count  out  STATS_W  count of completed frames.

Function
REQ-016 SHALL implement states S_HDR (await header), S_PAY (emit payload), S_DROP (discard payload).
REQ-017 SHALL never assert fifo_re while fifo_empty is high, because the FIFO does not guard underflow.
REQ-018 In S_HDR, SHALL assert fifo_re when !fifo_empty and latch len = fifo_data[LEN_W-1:0] into a remaining-word counter.
REQ-019 For a popped header with len==0, SHALL stay in S_HDR (empty frame, no output, frame_count unchanged); for len!=0 SHALL go to S_PAY.
REQ-020 In S_PAY, SHALL assert fifo_re when !fifo_empty && (!m_valid || m_ready), giving a sustained rate of 1 word/cycle.
REQ-021 On each S_PAY pop, SHALL load m_data <= fifo_data, set m_valid next cycle (latency 1 cycle), decrement the counter, and set m_last when counter==1.
REQ-022 On popping the final payload word, SHALL return to S_HDR next cycle and increment frame_count, which wraps modulo 2^STATS_W.
REQ-023 In S_HDR, SHALL pop the next header even while m_valid is held by a stalled final word; m_data, m_valid and m_last SHALL stay stable until accepted.
REQ-024 When m_valid && !m_ready and no new pop occurs, SHALL hold m_data, m_valid and m_last unchanged.
REQ-025 On flush in S_PAY, SHALL clear m_valid and m_last next cycle, go to S_DROP if counter!=0 (no count increment), and otherwise go to S_HDR.
REQ-026 In S_DROP, SHALL assert fifo_re when !fifo_empty, ignore m_ready, keep m_valid low, decrement the counter, and go to S_HDR after the last word without incrementing frame_count.
REQ-027 SHALL ignore flush in S_HDR and S_DROP.
REQ-028 Counter arithmetic SHALL be LEN_W bits; a maximum len of 2^LEN_W-1 SHALL produce exactly that many words.

Reset
REQ-029 When rst==0 at a clock edge, SHALL set state=S_HDR, counter=0, m_valid=0, m_last=0, m_data=0, frame_count=0, and busy=0.
REQ-030 During reset, SHALL hold fifo_re at 0.
REQ-031 Reset mid-frame SHALL discard the frame; the FIFO SHALL be reset together with this block, and leftover payload is otherwise parsed as a header.

Configuration
REQ-032 SHALL provide macro FIFO_FRAME_READER_STATS_EN: when defined, frame_count counts per REQ-022; when undefined, frame_count is tied to 0 and no counter register is built.

Structure
REQ-033 Package fifo_frame_pkg SHALL hold the state enum (S_HDR, S_PAY, S_DROP) and header field localparams (length LSB/MSB).
REQ-034 The output register with hold/accept logic SHALL be sub-module fifo_frame_reader_ostage (WIDTH data plus last, valid/ready).

Verification
REQ-035 Bench SHALL cover: FIFO holding header 3 then A,B,C with m_ready=1 -> fifo_re on 4 consecutive cycles, m_valid for 3 cycles with A,B,C, m_last only with C, frame_count=1.
REQ-036 Bench SHALL cover: header 0 then header 1 then D -> no output for the first frame, one word D with m_last=1, frame_count=1.
REQ-037 Bench SHALL cover: header 2, E, F with m_ready=0 for 5 cycles -> m_data=E held, fifo_re low after the E pop, then F delivered with m_last=1 once m_ready=1.
REQ-038 Bench SHALL cover: header 4, G,H,I,J with flush after H is accepted -> m_valid low, I and J popped silently, frame_count unchanged, next header parsed correctly.
REQ-039 Bench SHALL cover: fifo_empty toggling every cycle during a 5-word frame -> fifo_re never high while empty, all 5 words delivered in order.
REQ-040 Bench SHALL cover: rst=0 asserted mid-payload -> all outputs at reset values the next cycle, and fifo_re=0 while rst=0.
